pcie_rq_arbiter: RTL and testbench

PCIE_RQ_ARBITER -- requirements
Module: pcie_rq_arbiter

---
 rtl/pcie_rq_arbiter.sv | 135 +++++++++++++
 tb/tb_pcie_rq_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rq_arbiter.sv
// Two-source AXI-Stream RQ arbiter feeding the PCIe core: packet-locked round-robin
// grant with a one-entry registered output stage and per-source packet counters.
module pcie_rq_arbiter #(
    parameter int C_DATA_WIDTH        = 128,
    parameter int AXI4_RQ_TUSER_WIDTH = 62,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32
) (
    input  logic                           user_clk,
    input  logic                           user_reset,
    input  logic                           user_lnk_up,

    input  logic [C_DATA_WIDTH-1:0]        s0_axis_rq_tdata,
    input  logic [AXI4_RQ_TUSER_WIDTH-1:0] s0_axis_rq_tuser,
    input  logic [KEEP_WIDTH-1:0]          s0_axis_rq_tkeep,
    input  logic                           s0_axis_rq_tlast,
    input  logic                           s0_axis_rq_tvalid,
    output logic [3:0]                     s0_axis_rq_tready,

    input  logic [C_DATA_WIDTH-1:0]        s1_axis_rq_tdata,
    input  logic [AXI4_RQ_TUSER_WIDTH-1:0] s1_axis_rq_tuser,
    input  logic [KEEP_WIDTH-1:0]          s1_axis_rq_tkeep,
    input  logic                           s1_axis_rq_tlast,
    input  logic                           s1_axis_rq_tvalid,
    output logic [3:0]                     s1_axis_rq_tready,

    output logic [C_DATA_WIDTH-1:0]        m_axis_rq_tdata,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0] m_axis_rq_tuser,
    output logic [KEEP_WIDTH-1:0]          m_axis_rq_tkeep,
    output logic                           m_axis_rq_tlast,
    output logic                           m_axis_rq_tvalid,
    input  logic [3:0]                     m_axis_rq_tready,

    output logic [1:0]                     arb_grant,
    output logic [15:0]                    pkt_cnt0,
    output logic [15:0]                    pkt_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_t;

    state_t state;
    state_t state_next;
    logic   rr_ptr;
    logic   rr_ptr_next;

    logic   rst;
    logic   core_ready;
    logic   out_free;
    logic   rdy0;
    logic   rdy1;
    logic   acc0;
    logic   acc1;
    logic   acc_last;

    // A dropped link is treated exactly like reset.
    assign rst        = user_reset | ~user_lnk_up;
    assign core_ready = |m_axis_rq_tready;
    assign out_free   = ~m_axis_rq_tvalid | core_ready;

    assign rdy0 = ~rst & (state == ST_GNT0) & out_free;
    assign rdy1 = ~rst & (state == ST_GNT1) & out_free;
    assign acc0 = s0_axis_rq_tvalid & rdy0;
    assign acc1 = s1_axis_rq_tvalid & rdy1;
    assign acc_last = acc0 ? s0_axis_rq_tlast : s1_axis_rq_tlast;

    assign s0_axis_rq_tready = {4{rdy0}};
    assign s1_axis_rq_tready = {4{rdy1}};
    assign arb_grant         = state;

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        unique case (state)
            ST_IDLE: begin
                // rr_ptr always points away from the source just granted,
                // so each source alternates as tie winner.
                if (s0_axis_rq_tvalid && s1_axis_rq_tvalid) begin
                    state_next  = rr_ptr ? ST_GNT1 : ST_GNT0;
                    rr_ptr_next = ~rr_ptr;
                end else if (s0_axis_rq_tvalid) begin
                    state_next  = ST_GNT0;
                    rr_ptr_next = 1'b1;
                end else if (s1_axis_rq_tvalid) begin
                    state_next  = ST_GNT1;
                    rr_ptr_next = 1'b0;
                end
            end
            ST_GNT0: if (acc0 && s0_axis_rq_tlast) state_next = ST_IDLE;
            ST_GNT1: if (acc1 && s1_axis_rq_tlast) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            m_axis_rq_tvalid <= 1'b0;
            m_axis_rq_tdata  <= '0;
            m_axis_rq_tuser  <= '0;
            m_axis_rq_tkeep  <= '0;
            m_axis_rq_tlast  <= 1'b0;
        end else if (acc0 || acc1) begin
            m_axis_rq_tvalid <= 1'b1;
            m_axis_rq_tdata  <= acc0 ? s0_axis_rq_tdata : s1_axis_rq_tdata;
            m_axis_rq_tuser  <= acc0 ? s0_axis_rq_tuser : s1_axis_rq_tuser;
            m_axis_rq_tkeep  <= acc0 ? s0_axis_rq_tkeep : s1_axis_rq_tkeep;
            m_axis_rq_tlast  <= acc_last;
        end else if (core_ready) begin
            m_axis_rq_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            pkt_cnt0 <= 16'h0000;
            pkt_cnt1 <= 16'h0000;
        end else begin
            if (acc0 && s0_axis_rq_tlast) pkt_cnt0 <= pkt_cnt0 + 16'h0001;
            if (acc1 && s1_axis_rq_tlast) pkt_cnt1 <= pkt_cnt1 + 16'h0001;
        end
    end

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Table-driven bench for pcie_rq_arbiter: per-cycle input rows with hand-computed
// expected outputs, plus a counter-wrap sequence.
module tb_pcie_rq_arbiter;

    localparam int DW = 128;
    localparam int UW = 62;
    localparam int KW = DW / 32;

    logic          user_clk = 1'b0;
    logic          user_reset;
    logic          user_lnk_up;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
    logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
    logic          s0_tlast, s1_tlast, m_tlast;
    logic          s0_tvalid, s1_tvalid, m_tvalid;
    logic [3:0]    s0_tready, s1_tready, m_tready;
    logic [1:0]    arb_grant;
    logic [15:0]   pkt_cnt0, pkt_cnt1;

    int checks   = 0;
    int failures = 0;

    pcie_rq_arbiter #(
        .C_DATA_WIDTH(DW),
        .AXI4_RQ_TUSER_WIDTH(UW),
        .KEEP_WIDTH(KW)
    ) dut (
        .user_clk(user_clk),
        .user_reset(user_reset),
        .user_lnk_up(user_lnk_up),
        .s0_axis_rq_tdata(s0_tdata),
        .s0_axis_rq_tuser(s0_tuser),
        .s0_axis_rq_tkeep(s0_tkeep),
        .s0_axis_rq_tlast(s0_tlast),
        .s0_axis_rq_tvalid(s0_tvalid),
        .s0_axis_rq_tready(s0_tready),
        .s1_axis_rq_tdata(s1_tdata),
        .s1_axis_rq_tuser(s1_tuser),
        .s1_axis_rq_tkeep(s1_tkeep),
        .s1_axis_rq_tlast(s1_tlast),
        .s1_axis_rq_tvalid(s1_tvalid),
        .s1_axis_rq_tready(s1_tready),
        .m_axis_rq_tdata(m_tdata),
        .m_axis_rq_tuser(m_tuser),
        .m_axis_rq_tkeep(m_tkeep),
        .m_axis_rq_tlast(m_tlast),
        .m_axis_rq_tvalid(m_tvalid),
        .m_axis_rq_tready(m_tready),
        .arb_grant(arb_grant),
        .pkt_cnt0(pkt_cnt0),
        .pkt_cnt1(pkt_cnt1)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic        rst;
        logic        lnk;
        logic        v0;
        logic        l0;
        logic [7:0]  d0;
        logic        v1;
        logic        l1;
        logic [7:0]  d1;
        logic [3:0]  rdy;
        logic [1:0]  eg;
        logic        er0;
        logic        er1;
        logic        emv;
        logic [7:0]  emd;
        logic        eml;
        logic [15:0] ec0;
        logic [15:0] ec1;
    } vec_t;

    vec_t vecs[$];

    // Sideband fields are derived from the data byte so passthrough is checkable.
    function automatic logic [KW-1:0] keep_of(input logic [7:0] d);
        return (d == 8'h00) ? '0 : (d[3:0] ^ 4'hA);
    endfunction

    function automatic logic [UW-1:0] user_of(input logic [7:0] d);
        return (d == 8'h00) ? '0 : {46'b0, d, ~d};
    endfunction

    function automatic vec_t row(input logic rst, input logic lnk,
                                 input logic v0, input logic l0, input logic [7:0] d0,
                                 input logic v1, input logic l1, input logic [7:0] d1,
                                 input logic [3:0] rdy, input logic [1:0] eg,
                                 input logic er0, input logic er1, input logic emv,
                                 input logic [7:0] emd, input logic eml,
                                 input logic [15:0] ec0, input logic [15:0] ec1);
        vec_t r;
        r.rst = rst; r.lnk = lnk;
        r.v0 = v0; r.l0 = l0; r.d0 = d0;
        r.v1 = v1; r.l1 = l1; r.d1 = d1;
        r.rdy = rdy; r.eg = eg; r.er0 = er0; r.er1 = er1;
        r.emv = emv; r.emd = emd; r.eml = eml; r.ec0 = ec0; r.ec1 = ec1;
        return r;
    endfunction

    task automatic cmp(input string name, input int idx,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL row %0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge user_clk);
        user_reset = v.rst;
        user_lnk_up = v.lnk;
        s0_tvalid = v.v0;
        s0_tlast  = v.l0;
        s0_tdata  = {120'b0, v.d0};
        s0_tkeep  = keep_of(v.d0);
        s0_tuser  = user_of(v.d0);
        s1_tvalid = v.v1;
        s1_tlast  = v.l1;
        s1_tdata  = {120'b0, v.d1};
        s1_tkeep  = keep_of(v.d1);
        s1_tuser  = user_of(v.d1);
        m_tready  = v.rdy;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        cmp("arb_grant", idx, DW'(arb_grant), DW'(v.eg));
        cmp("s0_tready", idx, DW'(s0_tready), DW'({4{v.er0}}));
        cmp("s1_tready", idx, DW'(s1_tready), DW'({4{v.er1}}));
        cmp("m_tvalid",  idx, DW'(m_tvalid),  DW'(v.emv));
        cmp("m_tdata",   idx, m_tdata,        {120'b0, v.emd});
        cmp("m_tkeep",   idx, DW'(m_tkeep),   DW'(keep_of(v.emd)));
        cmp("m_tuser",   idx, DW'(m_tuser),   DW'(user_of(v.emd)));
        cmp("m_tlast",   idx, DW'(m_tlast),   DW'(v.eml));
        cmp("pkt_cnt0",  idx, DW'(pkt_cnt0),  DW'(v.ec0));
        cmp("pkt_cnt1",  idx, DW'(pkt_cnt1),  DW'(v.ec1));
    endtask

    initial begin
        vec_t idle;
        vec_t wv;
        idle = row(0,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 0,0,0, 0,8'h00,0, 0,0);

        // Single beat from s0
        vecs.push_back(row(0,1, 1,1,8'hA5, 0,0,8'h00, 4'hF, 2'd0,0,0, 0,8'h00,0, 16'd0,16'd0));
        vecs.push_back(row(0,1, 1,1,8'hA5, 0,0,8'h00, 4'hF, 2'd1,1,0, 0,8'h00,0, 16'd0,16'd0));
        vecs.push_back(row(0,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 2'd0,0,0, 1,8'hA5,1, 16'd1,16'd0));
        vecs.push_back(row(0,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 2'd0,0,0, 0,8'hA5,1, 16'd1,16'd0));
        // Reset to restore rr_ptr=0
        vecs.push_back(row(1,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 2'd0,0,0, 0,8'hA5,1, 16'd1,16'd0));
        // Simultaneous 2-beat packets, then a second tie
        vecs.push_back(row(0,1, 1,0,8'h01, 1,0,8'h11, 4'hF, 2'd0,0,0, 0,8'h00,0, 16'd0,16'd0));
        vecs.push_back(row(0,1, 1,0,8'h01, 1,0,8'h11, 4'hF, 2'd1,1,0, 0,8'h00,0, 16'd0,16'd0));
        vecs.push_back(row(0,1, 1,1,8'h02, 1,0,8'h11, 4'hF, 2'd1,1,0, 1,8'h01,0, 16'd0,16'd0));
        vecs.push_back(row(0,1, 0,0,8'h00, 1,0,8'h11, 4'hF, 2'd0,0,0, 1,8'h02,1, 16'd1,16'd0));
        vecs.push_back(row(0,1, 0,0,8'h00, 1,0,8'h11, 4'hF, 2'd2,0,1, 0,8'h02,1, 16'd1,16'd0));
        vecs.push_back(row(0,1, 0,0,8'h00, 1,1,8'h12, 4'hF, 2'd2,0,1, 1,8'h11,0, 16'd1,16'd0));
        vecs.push_back(row(0,1, 1,1,8'h03, 1,1,8'h13, 4'hF, 2'd0,0,0, 1,8'h12,1, 16'd1,16'd1));
        vecs.push_back(row(0,1, 1,1,8'h03, 1,1,8'h13, 4'hF, 2'd1,1,0, 0,8'h12,1, 16'd1,16'd1));
        vecs.push_back(row(0,1, 0,0,8'h00, 1,1,8'h13, 4'hF, 2'd0,0,0, 1,8'h03,1, 16'd2,16'd1));
        vecs.push_back(row(0,1, 0,0,8'h00, 1,1,8'h13, 4'hF, 2'd2,0,1, 0,8'h03,1, 16'd2,16'd1));
        vecs.push_back(row(0,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 2'd0,0,0, 1,8'h13,1, 16'd2,16'd2));
        // Backpressure for 5 cycles while holding beat 0x21
        vecs.push_back(row(0,1, 1,0,8'h21, 0,0,8'h00, 4'hF, 2'd0,0,0, 0,8'h13,1, 16'd2,16'd2));
        vecs.push_back(row(0,1, 1,0,8'h21, 0,0,8'h00, 4'hF, 2'd1,1,0, 0,8'h13,1, 16'd2,16'd2));
        for (int k = 0; k < 5; k++)
            vecs.push_back(row(0,1, 1,1,8'h22, 0,0,8'h00, 4'h0, 2'd1,0,0, 1,8'h21,0, 16'd2,16'd2));
        vecs.push_back(row(0,1, 1,1,8'h22, 0,0,8'h00, 4'h2, 2'd1,1,0, 1,8'h21,0, 16'd2,16'd2));
        vecs.push_back(row(0,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 2'd0,0,0, 1,8'h22,1, 16'd3,16'd2));
        vecs.push_back(row(0,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 2'd0,0,0, 0,8'h22,1, 16'd3,16'd2));
        // s1 packet with a 3-cycle tvalid gap, s0 waiting
        vecs.push_back(row(0,1, 0,0,8'h00, 1,0,8'h31, 4'hF, 2'd0,0,0, 0,8'h22,1, 16'd3,16'd2));
        vecs.push_back(row(0,1, 1,1,8'h41, 1,0,8'h31, 4'hF, 2'd2,0,1, 0,8'h22,1, 16'd3,16'd2));
        vecs.push_back(row(0,1, 1,1,8'h41, 0,0,8'h00, 4'hF, 2'd2,0,1, 1,8'h31,0, 16'd3,16'd2));
        vecs.push_back(row(0,1, 1,1,8'h41, 0,0,8'h00, 4'hF, 2'd2,0,1, 0,8'h31,0, 16'd3,16'd2));
        vecs.push_back(row(0,1, 1,1,8'h41, 0,0,8'h00, 4'hF, 2'd2,0,1, 0,8'h31,0, 16'd3,16'd2));
        vecs.push_back(row(0,1, 1,1,8'h41, 1,1,8'h32, 4'hF, 2'd2,0,1, 0,8'h31,0, 16'd3,16'd2));
        vecs.push_back(row(0,1, 1,1,8'h41, 0,0,8'h00, 4'hF, 2'd0,0,0, 1,8'h32,1, 16'd3,16'd3));
        vecs.push_back(row(0,1, 1,1,8'h41, 0,0,8'h00, 4'hF, 2'd1,1,0, 0,8'h32,1, 16'd3,16'd3));
        vecs.push_back(row(0,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 2'd0,0,0, 1,8'h41,1, 16'd4,16'd3));
        // Link drop in the middle of an s0 packet
        vecs.push_back(row(0,1, 1,0,8'h51, 0,0,8'h00, 4'hF, 2'd0,0,0, 0,8'h41,1, 16'd4,16'd3));
        vecs.push_back(row(0,1, 1,0,8'h51, 0,0,8'h00, 4'hF, 2'd1,1,0, 0,8'h41,1, 16'd4,16'd3));
        vecs.push_back(row(0,0, 1,1,8'h52, 0,0,8'h00, 4'hF, 2'd1,0,0, 1,8'h51,0, 16'd4,16'd3));
        vecs.push_back(row(0,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 2'd0,0,0, 0,8'h00,0, 16'd0,16'd0));

        idle.rst = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(idle);
        idle.rst = 1'b0;
        $display("[TB] reset released, applying %0d vectors", vecs.size());

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Counter wrap: preload pkt_cnt0 and send one more s0 packet
        @(negedge user_clk);
        force dut.pkt_cnt0 = 16'hFFFF;
        #1 release dut.pkt_cnt0;
        wv = row(0,1, 1,1,8'h61, 0,0,8'h00, 4'hF, 2'd0,0,0, 0,8'h00,0, 16'hFFFF,16'd0);
        applyStimulus(wv);
        checkOutput(wv, 100);
        wv.eg = 2'd1; wv.er0 = 1'b1;
        applyStimulus(wv);
        checkOutput(wv, 101);
        wv = row(0,1, 0,0,8'h00, 0,0,8'h00, 4'hF, 2'd0,0,0, 1,8'h61,1, 16'h0000,16'd0);
        applyStimulus(wv);
        checkOutput(wv, 102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
